// File: rtl/adler32_pkg.sv
// Shared constants and state encoding for the Adler-32 receive checker
// and any transmit-side accumulator that reuses the fold step.
package adler32_pkg;

   localparam logic [15:0] ADLER_MOD    = 16'd65521;
   localparam logic [15:0] ADLER_INIT_A = 16'h0001;
   localparam logic [15:0] ADLER_INIT_B = 16'h0000;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      TRAIL,
      RESULT
   } state_e;

endpackage

// File: rtl/adler32_update.sv
// One-byte Adler-32 fold: (A, B, d) -> (A', B'), each sum reduced once modulo MOD.
// Inputs are assumed already reduced (A, B < MOD), so one conditional subtract suffices.
module adler32_update
   import adler32_pkg::*;
#(
   parameter logic [15:0] MOD = ADLER_MOD
) (
   input  logic [15:0] a_in,
   input  logic [15:0] b_in,
   input  logic [7:0]  d,
   output logic [15:0] a_out,
   output logic [15:0] b_out
);

   logic [16:0] a_sum;
   logic [16:0] b_sum;

   // >= rather than >: a sum landing exactly on MOD must wrap to zero.
   always_comb begin
      a_sum = {1'b0, a_in} + {9'b0, d};
      a_out = (a_sum >= {1'b0, MOD}) ? 16'(a_sum - {1'b0, MOD}) : a_sum[15:0];
      b_sum = {1'b0, b_in} + {1'b0, a_out};
      b_out = (b_sum >= {1'b0, MOD}) ? 16'(b_sum - {1'b0, MOD}) : b_sum[15:0];
   end

endmodule

// File: rtl/adler32_check.sv
// Receive-side Adler-32 verifier: folds a frame's payload, shifts in the
// big-endian 4-byte trailer, then reports match/mismatch for one cycle.
module adler32_check
   import adler32_pkg::*;
#(
   parameter logic [15:0] MOD    = ADLER_MOD,
   parameter logic [15:0] INIT_A = ADLER_INIT_A
) (
   input  logic        clock,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   input  logic        in_first,
   input  logic        in_last,
   output logic        done,
   output logic        match,
   output logic        aborted,
   output logic [31:0] checksum,
   output logic [31:0] rx_checksum
);

   state_e      state_q, state_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] rx_q, rx_d;
   logic [31:0] sum_q, sum_d;
   logic        match_q, match_d;
   logic        done_q, done_d;
   logic        aborted_q, aborted_d;
   logic        in_ready_q, in_ready_d;

   logic        xfer;
   logic [15:0] a_base, b_base;
   logic [15:0] a_fold, b_fold;
   logic [31:0] rx_next;

   // A first byte always restarts from the initial sums, whatever state we are in.
   assign a_base = in_first ? INIT_A : a_q;
   assign b_base = in_first ? ADLER_INIT_B : b_q;

   adler32_update #(.MOD(MOD)) u_update (
      .a_in  (a_base),
      .b_in  (b_base),
      .d     (in_data),
      .a_out (a_fold),
      .b_out (b_fold)
   );

   assign xfer    = in_valid && in_ready_q;
   assign rx_next = {rx_q[23:0], in_data};

   always_comb begin
      // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      cnt_d     = cnt_q;
      rx_d      = rx_q;
      sum_d     = sum_q;
      match_d   = match_q;
      done_d    = 1'b0;
      aborted_d = 1'b0;

      case (state_q)
         IDLE, DATA, TRAIL: begin
            if (xfer && in_first) begin
               aborted_d = (state_q != IDLE);
               a_d       = a_fold;
               b_d       = b_fold;
               cnt_d     = 2'd0;
               state_d   = in_last ? TRAIL : DATA;
            end else if (xfer && state_q == DATA) begin
               a_d = a_fold;
               b_d = b_fold;
               if (in_last) begin
                  cnt_d   = 2'd0;
                  state_d = TRAIL;
               end
            end else if (xfer && state_q == TRAIL) begin
               rx_d  = rx_next;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  sum_d   = {b_q, a_q};
                  match_d = ({b_q, a_q} == rx_next);
                  done_d  = 1'b1;
                  state_d = RESULT;
               end
            end
         end
         RESULT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      in_ready_d = (state_d != RESULT);
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         a_q        <= INIT_A;
         b_q        <= ADLER_INIT_B;
         cnt_q      <= 2'd0;
         rx_q       <= 32'h0;
         sum_q      <= {ADLER_INIT_B, INIT_A};
         match_q    <= 1'b0;
         done_q     <= 1'b0;
         aborted_q  <= 1'b0;
         in_ready_q <= 1'b1;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values of the others.
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         cnt_q      <= cnt_d;
         rx_q       <= rx_d;
         sum_q      <= sum_d;
         match_q    <= match_d;
         done_q     <= done_d;
         aborted_q  <= aborted_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign done        = done_q;
   assign match       = match_q;
   assign aborted     = aborted_q;
   assign checksum    = sum_q;
   assign rx_checksum = rx_q;

endmodule

// File: tb/tb_adler32_check.sv
// Scoreboard bench for adler32_check: stimulus pushes expected verdicts,
// a negedge monitor pops and compares them whenever done pulses.
module tb_adler32_check;

   logic        clock = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_first = 1'b0;
   logic        in_last = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready;
   logic        done;
   logic        match;
   logic        aborted;
   logic [31:0] checksum;
   logic [31:0] rx_checksum;

   adler32_check dut (
      .clock       (clock),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_first    (in_first),
      .in_last     (in_last),
      .done        (done),
      .match       (match),
      .aborted     (aborted),
      .checksum    (checksum),
      .rx_checksum (rx_checksum)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] sum;
      logic [31:0] rx;
      logic        match;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   aborts_sent = 0;
   int   aborts_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference Adler-32 straight from the definition.
   function automatic logic [31:0] adler_ref(input byte unsigned data[$]);
      int unsigned a = 1;
      int unsigned b = 0;
      foreach (data[i]) begin
         a = (a + data[i]) % 65521;
         b = (b + a) % 65521;
      end
      return {b[15:0], a[15:0]};
   endfunction

   task automatic send(input logic [7:0] d, input logic f, input logic l, input int gap);
      int waited = 0;
      repeat (gap) begin
         @(negedge clock);
         in_valid = 1'b0;
      end
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = d;
      in_first = f;
      in_last  = l;
      while (!in_ready && waited < 20) begin
         @(negedge clock);
         waited++;
      end
      if (!in_ready) check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
      @(posedge clock);
      #1;
   endtask

   task automatic go_idle();
      @(negedge clock);
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_frame(input byte unsigned p[$], input logic [31:0] trailer,
                             input logic [31:0] exp_sum, input int gmax);
      exp_t e;
      for (int i = 0; i < p.size(); i++)
         send(p[i], i == 0, i == p.size() - 1, $urandom_range(0, gmax));
      for (int k = 0; k < 4; k++) begin
         if (k == 3) begin
            e.sum   = exp_sum;
            e.rx    = trailer;
            e.match = (trailer == exp_sum);
            exp_q.push_back(e);
         end
         send(trailer[31-8*k -: 8], 1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, gmax));
      end
      go_idle();
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done && n < 12) begin
         @(negedge clock);
         n++;
      end
      if (!done) check(name, {31'b0, done}, 32'd1);
   endtask

   // Monitor: every verdict the DUT presents is checked against the scoreboard.
   always @(negedge clock) begin
      if (rst_n) begin
         check("ready_vs_done", {31'b0, in_ready}, {31'b0, !done});
         if (done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", {31'b0, done}, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("checksum", checksum, e.sum);
               check("rx_checksum", rx_checksum, e.rx);
               check("match", {31'b0, match}, {31'b0, e.match});
            end
         end
         if (aborted) aborts_seen++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      byte unsigned p[$];
      logic [31:0]  r;
      logic [31:0]  t;
      exp_t         e;

      #1 rst_n = 1'b0;
      repeat (2) @(negedge clock);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_aborted", {31'b0, aborted}, 32'd0);
      check("rst_match", {31'b0, match}, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_checksum", checksum, 32'h0000_0001);
      check("rst_rx_checksum", rx_checksum, 32'h0);
      rst_n = 1'b1;

      p = '{8'h61, 8'h62, 8'h63};
      send_frame(p, 32'h024D_0127, 32'h024D_0127, 0);
      send_frame(p, 32'h024D_0128, 32'h024D_0127, 0);

      p = '{8'h00};
      send_frame(p, 32'h0001_0001, 32'h0001_0001, 0);

      // A lands exactly on the modulus after the last byte and must read 0.
      p.delete();
      repeat (256) p.push_back(8'hFF);
      p.push_back(8'hF0);
      r = adler_ref(p);
      send_frame(p, r, r, 0);
      wait_done("wrap_done_timeout");
      check("wrap_a_zero", {16'h0, checksum[15:0]}, 32'h0);

      // Trailer interrupted after two bytes by a new single-byte frame.
      send(8'h61, 1'b1, 1'b0, 0);
      send(8'h62, 1'b0, 1'b0, 0);
      send(8'h63, 1'b0, 1'b1, 0);
      send(8'h02, 1'b0, 1'b0, 0);
      send(8'h4D, 1'b0, 1'b0, 0);
      aborts_sent++;
      send(8'h61, 1'b1, 1'b1, 0);
      check("aborted_pulse", {31'b0, aborted}, 32'd1);
      send(8'h00, 1'b0, 1'b0, 0);
      send(8'h62, 1'b0, 1'b0, 0);
      send(8'h00, 1'b0, 1'b0, 0);
      e.sum = 32'h0062_0062; e.rx = 32'h0062_0062; e.match = 1'b1;
      exp_q.push_back(e);
      send(8'h62, 1'b0, 1'b0, 0);
      go_idle();

      p = '{8'h61, 8'h62, 8'h63};
      repeat (3) send_frame(p, 32'h024D_0127, 32'h024D_0127, 3);

      for (int f = 0; f < 10; f++) begin
         p.delete();
         repeat ($urandom_range(1, 24)) p.push_back(8'($urandom_range(0, 255)));
         r = adler_ref(p);
         t = ($urandom_range(0, 1) == 1) ? r : (r ^ (32'h1 << $urandom_range(0, 31)));
         send_frame(p, t, r, 2);
      end

      // Reset in the middle of a payload: immediate return to reset values, no verdict.
      wait_done("pre_reset_done_timeout");
      send(8'h11, 1'b1, 1'b0, 1);
      send(8'h22, 1'b0, 1'b0, 0);
      #2;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("midrst_checksum", checksum, 32'h0000_0001);
      check("midrst_rx_checksum", rx_checksum, 32'h0);
      check("midrst_match", {31'b0, match}, 32'd0);
      check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
      check("midrst_done", {31'b0, done}, 32'd0);
      repeat (2) @(negedge clock);
      rst_n = 1'b1;
      repeat (10) @(negedge clock);

      p = '{8'h61, 8'h62, 8'h63};
      send_frame(p, 32'h024D_0127, 32'h024D_0127, 1);

      repeat (8) @(negedge clock);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      check("abort_count", aborts_seen, aborts_sent);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
